mul_seq: RTL and testbench
==========================

Name: mul_seq

Overview:
- Iterative shift-add multiply controller. Replaces the single-cycle combinational multiplier in the execute stage.
- Sequences a one-bit-per-cycle datapath, produces a {hi,lo} product, and raises busy so the hazard logic can stall fetch, decode and execute.
- Results feed the lo/hi registers consumed by mfhi/mflo.

Parameters:
- WIDTH, 32, operand width in bits; product is 2*WIDTH.
- CNTW, $clog2(WIDTH+1), iteration counter width (derived; not overridden).

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- start  input  1  multu issued in execute stage; sampled only in IDLE
- flush  input  1  abort in-flight operation (branch/jump squash)
- srca  input  WIDTH  multiplicand (rd1E)
- srcb  input  WIDTH  multiplier (rd2E)
- busy  output  1  stall request to hazard logic
- done  output  1  one-cycle completion pulse
- lo  output  WIDTH  low half of last completed product
- hi  output  WIDTH  high half of last completed product

Behaviour:
- Single clock clk. Reset is synchronous and active-high on port reset. No asynchronous reset anywhere.
- Reset values: state=IDLE, count=0, acc=0, lo=0, hi=0, done=0. busy=0 unless start=1 in the same cycle.
- States:
  - IDLE: on start=1 && flush=0, latch mcand=srca, load acc={WIDTH'0, srcb}, count=0, go to RUN. Otherwise stay.
  - RUN: each cycle, if acc[0]=1 then upper = acc[2W-1:W] + mcand with the carry kept as bit W; acc <= {carry, upper-or-sum, acc[W-1:1]}. count++. When count==WIDTH-1, go to DONE.
  - DONE: lo<=acc[W-1:0], hi<=acc[2W-1:W], done=1 for exactly this cycle, then go to IDLE.
- busy = start&&state==IDLE || state!=IDLE. busy is combinational so the issuing instruction stalls in its own cycle.
- busy is low in the cycle after DONE, i.e. once back in IDLE with start=0.
- Latency: start sampled at edge 0; DONE state occupies cycle WIDTH+1; lo/hi are updated at the end of that cycle. Total busy = WIDTH+2 cycles.
- Arithmetic: unsigned. The add carry is captured into bit 2W-1 on the shift, so no overflow is lost. The full 64-bit product is exact.
- lo/hi hold their value until the next successful DONE. They are not cleared by start or flush.
- start while state!=IDLE is ignored. No queueing, no restart.
- flush has priority over everything except reset:
  - Any state goes to IDLE; done=0; lo/hi unchanged.
  - flush && start in the same cycle results in no operation launched.
- Reset mid-operation: back to the reset values above, with no done pulse.
- Operand changes on srca/srcb after start are ignored, because operands are latched.

Optional Feature:
- Macro MUL_SIGNED_EN.
- Defined:
  - Adds input port sgn (1 bit, sampled with start).
  - When sgn=1, operands are converted to magnitudes at latch time and the result sign neg=srca[W-1]^srcb[W-1] is stored.
  - DONE writes the two's-complement negation of the 2W-bit acc when neg=1.
  - Latency is unchanged.
- Undefined: no sgn port; unsigned only.

Decomposition:
- Package mul_seq_pkg holds:
  - state enum {IDLE, RUN, DONE} (2-bit encoding 00/01/10)
  - default WIDTH constant
- Sub-module mul_seq_dp holds the accumulator, multiplicand register and adder-shift step. It takes load/step controls and exposes acc.
- mul_seq keeps the FSM, counter, busy/done logic and the lo/hi registers.

Test Plan:
- Basic: reset, then start with srca=3, srcb=5. Expect busy high for 34 cycles, done pulse at cycle 33, lo=0x0000000F, hi=0.
- Max operands: srca=srcb=0xFFFFFFFF. Expect hi=0xFFFFFFFE, lo=0x00000001. Also srca=0x80000000, srcb=2 gives hi=1, lo=0.
- Start while busy: start at cycle 0 (7*6), start again at cycle 10 (9*9). Expect one done only, lo=42, no second operation; busy drops at cycle 34.
- Flush: start 0x1234*0x10, flush at cycle 12. Expect no done, IDLE next cycle, lo/hi retain the previous value (42). A fresh start then completes normally with lo=0x12340.
- Reset mid-op: reset asserted at cycle 20. Expect lo=hi=0, busy=0, done never pulses. flush+start in the same cycle launches nothing.
- MUL_SIGNED_EN: sgn=1, srca=0xFFFFFFFF (-1), srcb=2. Expect hi=0xFFFFFFFF, lo=0xFFFFFFFE. sgn=0 with the same operands gives hi=1, lo=0xFFFFFFFE.

Source files
------------

// File: rtl/mul_seq_pkg.sv
// Shared types for the iterative shift-add multiplier: FSM state encoding and default width.
package mul_seq_pkg;

  localparam int DEF_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } mul_state_e;

endpackage

// File: rtl/mul_seq_if.sv
// Execute-stage <-> multiplier handshake: launch/abort, operands, stall and product.
// The sgn field exists only when MUL_SIGNED_EN is defined.
interface mul_seq_if import mul_seq_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH
) ();

  logic             start;
  logic             flush;
  logic [WIDTH-1:0] srca;
  logic [WIDTH-1:0] srcb;
`ifdef MUL_SIGNED_EN
  logic             sgn;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] hi;

  modport master (
    output start, flush, srca, srcb,
`ifdef MUL_SIGNED_EN
    output sgn,
`endif
    input  busy, done, lo, hi
  );

  modport slave (
    input  start, flush, srca, srcb,
`ifdef MUL_SIGNED_EN
    input  sgn,
`endif
    output busy, done, lo, hi
  );

endinterface

// File: rtl/mul_seq_dp.sv
// Shift-add datapath: load latches multiplicand and seeds acc with the multiplier; each step
// consumes acc[0], adds the multiplicand into the upper half and shifts right one bit (1 cycle/step).
module mul_seq_dp import mul_seq_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               step,
  input  logic [WIDTH-1:0]   load_a,
  input  logic [WIDTH-1:0]   load_b,
  output logic [2*WIDTH-1:0] acc
);

  logic [WIDTH-1:0] mcand;
  logic [WIDTH:0]   upper_nx;

  // The add carry lands in bit WIDTH and is shifted into the top of acc, so nothing is lost.
  always_comb begin
    upper_nx = {1'b0, acc[2*WIDTH-1:WIDTH]};
    if (acc[0]) begin
      upper_nx = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, mcand};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc   <= '0;
      mcand <= '0;
    end else if (load) begin
      mcand <= load_a;
      acc   <= {{WIDTH{1'b0}}, load_b};
    end else if (step) begin
      acc   <= {upper_nx, acc[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/mul_seq.sv
// Iterative multiply controller: busy for WIDTH+2 cycles from start, one-cycle done, lo/hi held
// until the next completion. Define MUL_SIGNED_EN to add the sgn port for signed operands.
module mul_seq import mul_seq_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic     clk,
  input  logic     reset,
  mul_seq_if.slave bus
);

  localparam int CNTW = $clog2(WIDTH + 1);

  localparam logic [1:0] S_IDLE = 2'(IDLE);
  localparam logic [1:0] S_RUN  = 2'(RUN);
  localparam logic [1:0] S_DONE = 2'(DONE);

  localparam logic [CNTW-1:0] LAST = CNTW'(WIDTH - 1);

  logic [1:0]         state;
  logic [1:0]         state_nx;
  logic [CNTW-1:0]    count;
  logic               launch;
  logic               step;
  logic               done_int;
  logic [WIDTH-1:0]   op_a;
  logic [WIDTH-1:0]   op_b;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] result;
  logic [WIDTH-1:0]   lo_q;
  logic [WIDTH-1:0]   hi_q;

  assign launch   = (state == S_IDLE) && bus.start && !bus.flush;
  assign step     = (state == S_RUN) && !bus.flush;
  assign done_int = (state == S_DONE) && !bus.flush && !reset;

  // Combinational so the issuing instruction stalls in its own cycle.
  assign bus.busy = ((state == S_IDLE) && bus.start) || (state != S_IDLE);
  assign bus.done = done_int;
  assign bus.lo   = lo_q;
  assign bus.hi   = hi_q;

`ifdef MUL_SIGNED_EN
  logic neg;

  always_comb begin
    op_a = bus.srca;
    op_b = bus.srcb;
    if (bus.sgn && bus.srca[WIDTH-1]) op_a = -bus.srca;
    if (bus.sgn && bus.srcb[WIDTH-1]) op_b = -bus.srcb;
  end

  assign result = neg ? -acc : acc;

  always_ff @(posedge clk) begin
    if (reset) begin
      neg <= 1'b0;
    end else if (launch) begin
      neg <= bus.sgn && (bus.srca[WIDTH-1] ^ bus.srcb[WIDTH-1]);
    end
  end
`else
  assign op_a   = bus.srca;
  assign op_b   = bus.srcb;
  assign result = acc;
`endif

  mul_seq_dp #(.WIDTH(WIDTH)) u_dp (
    .clk    (clk),
    .reset  (reset),
    .load   (launch),
    .step   (step),
    .load_a (op_a),
    .load_b (op_b),
    .acc    (acc)
  );

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (launch) state_nx = S_RUN;
      S_RUN:   if (count == LAST) state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
    if (bus.flush) state_nx = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      count <= '0;
      lo_q  <= '0;
      hi_q  <= '0;
    end else begin
      state <= state_nx;
      if (launch) begin
        count <= '0;
      end else if (step) begin
        count <= count + 1'b1;
      end
      if (done_int) begin
        lo_q <= result[WIDTH-1:0];
        hi_q <= result[2*WIDTH-1:WIDTH];
      end
    end
  end

endmodule

// File: tb/tb_mul_seq.sv
// Directed bench for mul_seq: per-cycle timeline/product model plus hand-computed literals.
module tb_mul_seq;

  localparam int W = 32;

  logic clk;
  logic reset;
  int   n_chk;
  int   n_fail;
  int   cyc;
  bit   chk_en;

  mul_seq_if #(.WIDTH(W)) bus ();

  mul_seq #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [63:0] product(input logic [31:0] a, input logic [31:0] b,
                                          input logic s);
    if (s) return longint'($signed(a)) * longint'($signed(b));
    return {32'b0, a} * {32'b0, b};
  endfunction

  logic cur_sgn;
`ifdef MUL_SIGNED_EN
  assign cur_sgn = bus.sgn;
`else
  assign cur_sgn = 1'b0;
`endif

  // Model: an accepted start makes the unit busy for W+2 cycles; the last of these carries
  // done and the product becomes visible on lo/hi the cycle after.
  bit          m_active;
  int          m_elapsed;
  logic [63:0] m_prod;
  logic [31:0] m_lo;
  logic [31:0] m_hi;

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", bus.busy, m_active || bus.start);
      chk("done", bus.done, m_active && (m_elapsed == W + 1) && !bus.flush && !reset);
      chk("lo", bus.lo, m_lo);
      chk("hi", bus.hi, m_hi);
      if (reset) begin
        m_active = 0;
        m_lo     = '0;
        m_hi     = '0;
      end else if (bus.flush) begin
        m_active = 0;
      end else if (m_active) begin
        if (m_elapsed == W + 1) begin
          {m_hi, m_lo} = m_prod;
          m_active     = 0;
        end else begin
          m_elapsed++;
        end
      end else if (bus.start) begin
        m_active  = 1;
        m_elapsed = 1;
        m_prod    = product(bus.srca, bus.srcb, cur_sgn);
      end
    end
  end

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                        input int restart_at, input int flush_at, input int reset_at,
                        output int done_off, output int busy_len, output int ndone);
    done_off = -1;
    busy_len = 0;
    ndone    = 0;
    @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.srca  = a;
    bus.srcb  = b;
`ifdef MUL_SIGNED_EN
    bus.sgn   = s;
`endif
    bus.flush = (flush_at == 0);
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (bus.done) begin
        ndone++;
        done_off = k;
      end
      if (bus.busy) busy_len++;
      else break;
      @(posedge clk);
      #1;
      bus.start = (k + 1 == restart_at);
      bus.srca  = bus.start ? 32'd9 : $urandom;
      bus.srcb  = bus.start ? 32'd9 : $urandom;
`ifdef MUL_SIGNED_EN
      bus.sgn   = s ^ bus.start;
`endif
      bus.flush = (k + 1 == flush_at);
      reset     = (k + 1 == reset_at);
    end
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.flush = 1'b0;
    reset     = 1'b0;
    @(negedge clk);
  endtask

  int d_off, b_len, n_done;

  initial begin
    n_chk     = 0;
    n_fail    = 0;
    cyc       = 0;
    chk_en    = 0;
    m_active  = 0;
    m_elapsed = 0;
    m_prod    = '0;
    m_lo      = '0;
    m_hi      = '0;
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.flush = 1'b0;
    bus.srca  = '0;
    bus.srcb  = '0;
`ifdef MUL_SIGNED_EN
    bus.sgn   = 1'b0;
`endif
    @(posedge clk);
    #1;
    chk_en = 1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_lo", bus.lo, 0);
    chk("rst_hi", bus.hi, 0);

    run_op(32'd3, 32'd5, 1'b0, -1, -1, -1, d_off, b_len, n_done);
    chk("basic_done_off", d_off, 33);
    chk("basic_busy_len", b_len, 34);
    chk("basic_ndone", n_done, 1);
    chk("basic_lo", bus.lo, 32'h0000000F);
    chk("basic_hi", bus.hi, 0);

    run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, -1, -1, -1, d_off, b_len, n_done);
    chk("max_lo", bus.lo, 32'h00000001);
    chk("max_hi", bus.hi, 32'hFFFFFFFE);

    run_op(32'h80000000, 32'd2, 1'b0, -1, -1, -1, d_off, b_len, n_done);
    chk("msb_lo", bus.lo, 0);
    chk("msb_hi", bus.hi, 1);

    run_op(32'd7, 32'd6, 1'b0, 10, -1, -1, d_off, b_len, n_done);
    chk("restart_ndone", n_done, 1);
    chk("restart_busy_len", b_len, 34);
    chk("restart_lo", bus.lo, 42);
    chk("restart_hi", bus.hi, 0);

    run_op(32'h1234, 32'h10, 1'b0, -1, 12, -1, d_off, b_len, n_done);
    chk("flush_ndone", n_done, 0);
    chk("flush_busy_len", b_len, 13);
    chk("flush_lo_kept", bus.lo, 42);

    run_op(32'h1234, 32'h10, 1'b0, -1, -1, -1, d_off, b_len, n_done);
    chk("refill_done_off", d_off, 33);
    chk("refill_lo", bus.lo, 32'h00012340);
    chk("refill_hi", bus.hi, 0);

    run_op(32'h1234, 32'h10, 1'b0, -1, -1, 20, d_off, b_len, n_done);
    chk("rstmid_ndone", n_done, 0);
    chk("rstmid_busy_len", b_len, 21);
    chk("rstmid_lo", bus.lo, 0);
    chk("rstmid_hi", bus.hi, 0);
    chk("rstmid_busy", bus.busy, 0);

    run_op(32'd7, 32'd6, 1'b0, -1, 0, -1, d_off, b_len, n_done);
    chk("flstart_busy_len", b_len, 1);
    chk("flstart_ndone", n_done, 0);
    repeat (40) @(posedge clk);
    @(negedge clk);
    chk("flstart_lo", bus.lo, 0);
    chk("flstart_busy", bus.busy, 0);

`ifdef MUL_SIGNED_EN
    run_op(32'hFFFFFFFF, 32'd2, 1'b1, -1, -1, -1, d_off, b_len, n_done);
    chk("sgn_done_off", d_off, 33);
    chk("sgn_lo", bus.lo, 32'hFFFFFFFE);
    chk("sgn_hi", bus.hi, 32'hFFFFFFFF);
`endif
    run_op(32'hFFFFFFFF, 32'd2, 1'b0, -1, -1, -1, d_off, b_len, n_done);
    chk("uns_lo", bus.lo, 32'hFFFFFFFE);
    chk("uns_hi", bus.hi, 1);

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
